// File: rtl/pwls_sched_pkg.sv
// rtl/pwls_sched_pkg.sv - shared constants, channel parameter struct and config decode helpers
package pwls_sched_pkg;

    localparam int NUM_CHANNELS      = 4;
    localparam int CH_BITS           = $clog2(NUM_CHANNELS);
    localparam int BITS              = 12;
    localparam int BITS_E            = 13;
    localparam int OCT_BITS          = 3;
    localparam int MANTISSA_BITS     = 10;
    localparam int DETUNE_EXP_BITS   = 3;
    localparam int SLOPE_EXP_BITS    = 4;
    localparam int CFG_DATA_BITS     = 16;
    localparam int AMP_BITS          = 10;
    localparam int CHANNEL_MODE_BITS = 2;

    // ALU sequencing constants shared with the pwl_synth datapath
    localparam int                    STATE_BITS = 3;
    localparam logic [STATE_BITS-1:0] STATE_LAST = 3'd7;

    localparam int                       SRC1_SEL_BITS         = 3;
    localparam logic [SRC1_SEL_BITS-1:0] SRC1_SEL_PHASE        = 3'd0;
    localparam logic [SRC1_SEL_BITS-1:0] SRC1_SEL_MANTISSA     = 3'd1;
    localparam logic [SRC1_SEL_BITS-1:0] SRC1_SEL_TRI_OFFSET   = 3'd2;
    localparam logic [SRC1_SEL_BITS-1:0] SRC1_SEL_SLOPE_OFFSET = 3'd3;
    localparam logic [SRC1_SEL_BITS-1:0] SRC1_SEL_AMP          = 3'd4;

    localparam int                       DEST_SEL_BITS  = 2;
    localparam logic [DEST_SEL_BITS-1:0] DEST_SEL_PHASE = 2'd1;

    // Host config register indices; each index is one independently written field group
    localparam int                       CFG_REG_BITS  = 3;
    localparam int                       CFG_GROUPS    = 5;
    localparam logic [CFG_REG_BITS-1:0]  CFG_REG_PITCH = 3'd0;
    localparam logic [CFG_REG_BITS-1:0]  CFG_REG_TRI   = 3'd1;
    localparam logic [CFG_REG_BITS-1:0]  CFG_REG_SLOPE = 3'd2;
    localparam logic [CFG_REG_BITS-1:0]  CFG_REG_AMP   = 3'd3;
    localparam logic [CFG_REG_BITS-1:0]  CFG_REG_MODE  = 3'd4;

    typedef struct packed {
        logic [OCT_BITS-1:0]          octave;
        logic [MANTISSA_BITS-1:0]     mantissa;
        logic [BITS-1:0]              tri_offset;
        logic [SLOPE_EXP_BITS-1:0]    slope_exp;
        logic [BITS-1:0]              slope_offset;
        logic [AMP_BITS-1:0]          amp;
        logic [CHANNEL_MODE_BITS-1:0] mode;
        logic [DETUNE_EXP_BITS-1:0]   detune_exp;
    } channel_params_t;

    // Apply one host write to a parameter set; data MSBs beyond the field group are dropped
    function automatic channel_params_t apply_cfg(input channel_params_t p,
                                                  input logic [CFG_REG_BITS-1:0] r,
                                                  input logic [CFG_DATA_BITS-1:0] d);
        channel_params_t upd;
        upd = p;
        case (r)
            CFG_REG_PITCH: {upd.octave, upd.mantissa}         = d[OCT_BITS+MANTISSA_BITS-1:0];
            CFG_REG_TRI:   upd.tri_offset                     = d[BITS-1:0];
            CFG_REG_SLOPE: {upd.slope_exp, upd.slope_offset}  = d[SLOPE_EXP_BITS+BITS-1:0];
            CFG_REG_AMP:   upd.amp                            = d[AMP_BITS-1:0];
            CFG_REG_MODE:  {upd.mode, upd.detune_exp}         = d[CHANNEL_MODE_BITS+DETUNE_EXP_BITS-1:0];
            default:       ;
        endcase
        return upd;
    endfunction

    // One-hot field group for a register index; unused indices map to no group
    function automatic logic [CFG_GROUPS-1:0] cfg_group_mask(input logic [CFG_REG_BITS-1:0] r);
        logic [CFG_GROUPS-1:0] m;
        m = '0;
        if (r < CFG_REG_BITS'(CFG_GROUPS)) m = CFG_GROUPS'(1) << r;
        return m;
    endfunction

    // Copy only the dirty field groups of a shadow set onto a live set
    function automatic channel_params_t merge_dirty(input channel_params_t live,
                                                    input channel_params_t shadow,
                                                    input logic [CFG_GROUPS-1:0] dirty);
        channel_params_t m;
        m = live;
        if (dirty[CFG_REG_PITCH]) {m.octave, m.mantissa}        = {shadow.octave, shadow.mantissa};
        if (dirty[CFG_REG_TRI])   m.tri_offset                  = shadow.tri_offset;
        if (dirty[CFG_REG_SLOPE]) {m.slope_exp, m.slope_offset} = {shadow.slope_exp, shadow.slope_offset};
        if (dirty[CFG_REG_AMP])   m.amp                         = shadow.amp;
        if (dirty[CFG_REG_MODE])  {m.mode, m.detune_exp}        = {shadow.mode, shadow.detune_exp};
        return m;
    endfunction

endpackage

// File: rtl/pwls_channel_scheduler_regfile.sv
// rtl/pwls_channel_scheduler_regfile.sv - per-channel parameter storage (pwls_param_regfile)
// Ports: i_clk/i_reset clock and async active-high reset; i_we/i_wr_ch/i_wr_reg/i_wr_data
// host write port; i_commit (PWLS_CFG_SHADOW_EN only) copies dirty shadow groups to live;
// i_rd_ch/o_rd_params combinational read of the live set.
// Build option: PWLS_CFG_SHADOW_EN selects shadowed writes committed on the sample tick.
module pwls_param_regfile
    import pwls_sched_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_we,
    input  logic [CH_BITS-1:0]       i_wr_ch,
    input  logic [CFG_REG_BITS-1:0]  i_wr_reg,
    input  logic [CFG_DATA_BITS-1:0] i_wr_data,
`ifdef PWLS_CFG_SHADOW_EN
    input  logic                     i_commit,
`endif
    input  logic [CH_BITS-1:0]       i_rd_ch,
    output channel_params_t          o_rd_params
);

    channel_params_t r_live [NUM_CHANNELS];

`ifdef PWLS_CFG_SHADOW_EN
    channel_params_t       r_shadow [NUM_CHANNELS];
    logic [CFG_GROUPS-1:0] r_dirty  [NUM_CHANNELS];

    // A write coinciding with a commit lands in the shadow and stays dirty for the next commit
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_live[i]   <= '0;
                r_shadow[i] <= '0;
                r_dirty[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (i_commit) r_live[i] <= merge_dirty(r_live[i], r_shadow[i], r_dirty[i]);
                if (i_we && (i_wr_ch == CH_BITS'(i))) begin
                    r_shadow[i] <= apply_cfg(r_shadow[i], i_wr_reg, i_wr_data);
                    r_dirty[i]  <= (i_commit ? '0 : r_dirty[i]) | cfg_group_mask(i_wr_reg);
                end else if (i_commit) begin
                    r_dirty[i] <= '0;
                end
            end
        end
    end
`else
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) r_live[i] <= '0;
        end else if (i_we) begin
            r_live[i_wr_ch] <= apply_cfg(r_live[i_wr_ch], i_wr_reg, i_wr_data);
        end
    end
`endif

    assign o_rd_params = r_live[i_rd_ch];

endmodule

// File: rtl/pwls_channel_scheduler.sv
// rtl/pwls_channel_scheduler.sv - time-multiplexes one pwls ALU across the synth channels
// Ports: i_clk, i_reset (async active-high); i_run gates sequencing; i_cfg_* / o_cfg_ready host
// parameter writes; o_alu_* control, active-channel params, src1 operand and phase to the ALU;
// i_alu_src1_sel/i_alu_dest_sel/i_alu_result from the ALU; o_sample_tick, o_cur_ch status.
// Build option: PWLS_CFG_SHADOW_EN buffers writes and applies them on the sample tick.
module pwls_channel_scheduler
    import pwls_sched_pkg::*;
(
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_run,
    input  logic                         i_cfg_valid,
    output logic                         o_cfg_ready,
    input  logic [CH_BITS-1:0]           i_cfg_ch,
    input  logic [CFG_REG_BITS-1:0]      i_cfg_reg,
    input  logic [CFG_DATA_BITS-1:0]     i_cfg_data,
    output logic                         o_alu_en,
    output logic [STATE_BITS-1:0]        o_alu_state,
    output logic                         o_alu_first_term,
    output logic                         o_alu_oct_counter_we,
    output logic                         o_alu_sub_channel,
    output logic [OCT_BITS-1:0]          o_alu_octave,
    output logic [MANTISSA_BITS-1:0]     o_alu_mantissa,
    output logic [BITS-1:0]              o_alu_tri_offset,
    output logic [SLOPE_EXP_BITS-1:0]    o_alu_slope_exp,
    output logic [BITS-1:0]              o_alu_slope_offset,
    output logic [AMP_BITS-1:0]          o_alu_amp,
    output logic [DETUNE_EXP_BITS-1:0]   o_alu_detune_exp,
    output logic [CHANNEL_MODE_BITS-1:0] o_alu_channel_mode,
    output logic [BITS_E-1:0]            o_alu_src1,
    output logic [BITS-1:0]              o_alu_phase,
    input  logic [SRC1_SEL_BITS-1:0]     i_alu_src1_sel,
    input  logic [DEST_SEL_BITS-1:0]     i_alu_dest_sel,
    input  logic [BITS-1:0]              i_alu_result,
    output logic                         o_sample_tick,
    output logic [CH_BITS-1:0]           o_cur_ch
);

    logic [STATE_BITS-1:0] r_state;
    logic [CH_BITS-1:0]    r_cur_ch;
    logic [BITS-1:0]       r_phase [NUM_CHANNELS];

    logic                  w_state_last;
    logic                  w_sample_tick;
    logic                  w_cfg_ready;
    logic                  w_cfg_we;
    channel_params_t       w_params;
    logic [BITS-1:0]       w_phase;
    logic [BITS_E-1:0]     w_src1;

    assign w_state_last  = (r_state == STATE_LAST);
    assign w_sample_tick = i_run & w_state_last & (r_cur_ch == CH_BITS'(NUM_CHANNELS - 1));

`ifdef PWLS_CFG_SHADOW_EN
    assign w_cfg_ready = 1'b1;
`else
    // Live registers are read combinationally, so the active channel cannot change mid-slot
    assign w_cfg_ready = ~(i_run & (i_cfg_ch == r_cur_ch));
`endif
    assign w_cfg_we = i_cfg_valid & w_cfg_ready;

    pwls_param_regfile u_regfile (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_we        (w_cfg_we),
        .i_wr_ch     (i_cfg_ch),
        .i_wr_reg    (i_cfg_reg),
        .i_wr_data   (i_cfg_data),
`ifdef PWLS_CFG_SHADOW_EN
        .i_commit    (w_sample_tick),
`endif
        .i_rd_ch     (r_cur_ch),
        .o_rd_params (w_params)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= '0;
            r_cur_ch <= '0;
        end else if (i_run) begin
            if (w_state_last) begin
                r_state  <= '0;
                r_cur_ch <= r_cur_ch + CH_BITS'(1);
            end else begin
                r_state  <= r_state + STATE_BITS'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) r_phase[i] <= '0;
        end else if (i_run && (i_alu_dest_sel == DEST_SEL_PHASE)) begin
            r_phase[r_cur_ch] <= i_alu_result;
        end
    end

    assign w_phase = r_phase[r_cur_ch];

    // tri_offset is a signed offset; every other operand is unsigned
    always_comb begin
        w_src1 = '0;
        case (i_alu_src1_sel)
            SRC1_SEL_PHASE:        w_src1 = {{(BITS_E-BITS){1'b0}}, w_phase};
            SRC1_SEL_MANTISSA:     w_src1 = {{(BITS_E-MANTISSA_BITS){1'b0}}, w_params.mantissa};
            SRC1_SEL_TRI_OFFSET:   w_src1 = {{(BITS_E-BITS){w_params.tri_offset[BITS-1]}}, w_params.tri_offset};
            SRC1_SEL_SLOPE_OFFSET: w_src1 = {{(BITS_E-BITS){1'b0}}, w_params.slope_offset};
            SRC1_SEL_AMP:          w_src1 = {{(BITS_E-AMP_BITS){1'b0}}, w_params.amp};
            default:               w_src1 = '0;
        endcase
    end

    assign o_cfg_ready          = w_cfg_ready;
    assign o_alu_en             = i_run;
    assign o_alu_state          = r_state;
    assign o_alu_first_term     = 1'b1;
    assign o_alu_oct_counter_we = w_sample_tick;
    assign o_alu_sub_channel    = r_cur_ch[0];
    assign o_alu_octave         = w_params.octave;
    assign o_alu_mantissa       = w_params.mantissa;
    assign o_alu_tri_offset     = w_params.tri_offset;
    assign o_alu_slope_exp      = w_params.slope_exp;
    assign o_alu_slope_offset   = w_params.slope_offset;
    assign o_alu_amp            = w_params.amp;
    assign o_alu_detune_exp     = w_params.detune_exp;
    assign o_alu_channel_mode   = w_params.mode;
    assign o_alu_src1           = w_src1;
    assign o_alu_phase          = w_phase;
    assign o_sample_tick        = w_sample_tick;
    assign o_cur_ch             = r_cur_ch;

endmodule

// File: tb/tb_pwls_channel_scheduler.sv
// tb/tb_pwls_channel_scheduler.sv - randomized self-checking bench against a behavioural model
module tb_pwls_channel_scheduler;
    import pwls_sched_pkg::*;

    localparam int STEPS = int'(STATE_LAST) + 1;

    logic        clk = 1'b0, reset = 1'b1, run = 1'b0, cfg_valid = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [2:0]  cfg_reg = '0;
    logic [15:0] cfg_data = '0;
    logic [2:0]  src1_sel = '0;
    logic [1:0]  dest_sel = '0;
    logic [11:0] alu_result = '0;

    logic        cfg_ready, alu_en, alu_first_term, alu_oct_we, alu_sub_ch, sample_tick;
    logic [2:0]  alu_state, alu_octave, alu_detune_exp;
    logic [9:0]  alu_mantissa, alu_amp;
    logic [11:0] alu_tri_offset, alu_slope_offset, alu_phase;
    logic [3:0]  alu_slope_exp;
    logic [1:0]  alu_mode, cur_ch;
    logic [12:0] alu_src1;

    pwls_channel_scheduler dut (
        .i_clk(clk), .i_reset(reset), .i_run(run),
        .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready), .i_cfg_ch(cfg_ch),
        .i_cfg_reg(cfg_reg), .i_cfg_data(cfg_data),
        .o_alu_en(alu_en), .o_alu_state(alu_state), .o_alu_first_term(alu_first_term),
        .o_alu_oct_counter_we(alu_oct_we), .o_alu_sub_channel(alu_sub_ch),
        .o_alu_octave(alu_octave), .o_alu_mantissa(alu_mantissa),
        .o_alu_tri_offset(alu_tri_offset), .o_alu_slope_exp(alu_slope_exp),
        .o_alu_slope_offset(alu_slope_offset), .o_alu_amp(alu_amp),
        .o_alu_detune_exp(alu_detune_exp), .o_alu_channel_mode(alu_mode),
        .o_alu_src1(alu_src1), .o_alu_phase(alu_phase),
        .i_alu_src1_sel(src1_sel), .i_alu_dest_sel(dest_sel), .i_alu_result(alu_result),
        .o_sample_tick(sample_tick), .o_cur_ch(cur_ch)
    );

    always #5 clk = ~clk;

    // Model: run-cycle count gives slot position; params kept as raw field-group values
    int m_cyc;
    int m_live[4][5], m_shadow[4][5], m_phase[4];
    bit m_dirty[4][5];
    int g_mask[5] = '{'h1FFF, 'hFFF, 'hFFFF, 'h3FF, 'h1F};
    int n_checks = 0, n_errors = 0;
    int wall = 0;
    bit last_acc, dut_rdy;
    int tick_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_ch();
        return (m_cyc / STEPS) % 4;
    endfunction

    function automatic int m_st();
        return m_cyc % STEPS;
    endfunction

    task automatic model_reset();
        m_cyc = 0;
        for (int c = 0; c < 4; c++) begin
            m_phase[c] = 0;
            for (int g = 0; g < 5; g++) begin
                m_live[c][g] = 0; m_shadow[c][g] = 0; m_dirty[c][g] = 0;
            end
        end
    endtask

    task automatic cycle();
        int ch, st, e;
        bit tick, rdy;
        @(negedge clk);
        ch = m_ch(); st = m_st();
        tick = run && (st == STEPS - 1) && (ch == 3);
`ifdef PWLS_CFG_SHADOW_EN
        rdy = 1'b1;
`else
        rdy = !(run && (int'(cfg_ch) == ch));
`endif
        check("state", alu_state, st);
        check("cur_ch", cur_ch, ch);
        check("sample_tick", sample_tick, tick);
        check("oct_we", alu_oct_we, tick);
        check("alu_en", alu_en, run);
        check("first_term", alu_first_term, 1);
        check("sub_ch", alu_sub_ch, ch % 2);
        check("cfg_ready", cfg_ready, rdy);
        check("octave", alu_octave, m_live[ch][0] >> 10);
        check("mantissa", alu_mantissa, m_live[ch][0] & 'h3FF);
        check("tri_offset", alu_tri_offset, m_live[ch][1]);
        check("slope_exp", alu_slope_exp, m_live[ch][2] >> 12);
        check("slope_offset", alu_slope_offset, m_live[ch][2] & 'hFFF);
        check("amp", alu_amp, m_live[ch][3]);
        check("mode", alu_mode, m_live[ch][4] >> 3);
        check("detune_exp", alu_detune_exp, m_live[ch][4] & 7);
        check("phase", alu_phase, m_phase[ch]);
        case (src1_sel)
            SRC1_SEL_PHASE:        e = m_phase[ch];
            SRC1_SEL_MANTISSA:     e = m_live[ch][0] & 'h3FF;
            SRC1_SEL_TRI_OFFSET:   begin e = m_live[ch][1]; if (e >= 'h800) e += 'h1000; end
            SRC1_SEL_SLOPE_OFFSET: e = m_live[ch][2] & 'hFFF;
            SRC1_SEL_AMP:          e = m_live[ch][3];
            default:               e = 0;
        endcase
        check("src1", alu_src1, e);
        if (sample_tick) tick_q.push_back(wall);
        dut_rdy  = cfg_ready;
        last_acc = cfg_valid && rdy;
        @(posedge clk);
        if (run && dest_sel == DEST_SEL_PHASE) m_phase[ch] = alu_result;
`ifdef PWLS_CFG_SHADOW_EN
        if (tick)
            for (int c = 0; c < 4; c++)
                for (int g = 0; g < 5; g++)
                    if (m_dirty[c][g]) begin m_live[c][g] = m_shadow[c][g]; m_dirty[c][g] = 0; end
        if (last_acc && cfg_reg < 5) begin
            m_shadow[cfg_ch][cfg_reg] = cfg_data & g_mask[cfg_reg];
            m_dirty[cfg_ch][cfg_reg]  = 1;
        end
`else
        if (last_acc && cfg_reg < 5) m_live[cfg_ch][cfg_reg] = cfg_data & g_mask[cfg_reg];
`endif
        if (run) m_cyc++;
        wall++;
        #1;
    endtask

    task automatic advance_to(input int ch, input int st);
        int n = 0;
        while (!(m_ch() == ch && m_st() == st) && n < 200) begin cycle(); n++; end
        check("advance_in_budget", (n < 200), 1);
    endtask

    task automatic write_cfg(input int ch, input int r, input int d);
        cfg_valid = 1; cfg_ch = 2'(ch); cfg_reg = 3'(r); cfg_data = 16'(d);
        cycle();
        cfg_valid = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls, c0;
        bit acc;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 0;
        cycle();                                    // reset state, run=0

        // Sample tick period and phase capture on channel 1
        run = 1; tick_q.delete(); wall = 0;
        for (int i = 0; i < 100; i++) begin
            dest_sel = (i == 10) ? DEST_SEL_PHASE : 2'd0;
            alu_result = 12'hABC;
            cycle();
            if (i == 33) check("phase_ch0_untouched", alu_phase, 0);
            if (i == 41) check("phase_ch1_abc", alu_phase, 'hABC);
        end
        dest_sel = 0;
        check("tick_count", tick_q.size(), 3);
        if (tick_q.size() == 3) begin
            check("tick_first", tick_q[0], 4 * STEPS - 1);
            check("tick_gap1", tick_q[1] - tick_q[0], 4 * STEPS);
            check("tick_gap2", tick_q[2] - tick_q[1], 4 * STEPS);
        end

        // Field truncation, ignored register index, sign extension
        run = 0; c0 = m_ch();
        write_cfg(c0, 0, 'hFFFF);
        write_cfg(c0, 1, 'h0800);
        write_cfg(c0, 6, 'hFFFF);
`ifdef PWLS_CFG_SHADOW_EN
        run = 1;
        repeat (4 * STEPS) cycle();
        run = 0;
`endif
        src1_sel = SRC1_SEL_TRI_OFFSET;
        #1;
        check("oct_trunc", alu_octave, 7);
        check("mant_trunc", alu_mantissa, 'h3FF);
        check("tri_sext", alu_src1, 'h1800);
        check("reg6_amp", alu_amp, 0);
        cycle();

        // Write to the active channel
        run = 1;
        advance_to(2, 0);
        cfg_valid = 1; cfg_ch = 2; cfg_reg = 3; cfg_data = 16'h0155;
        stalls = 0; acc = 0;
        for (int i = 0; i < 20 && !acc; i++) begin
            cycle();
            if (dut_rdy) acc = 1; else stalls++;
        end
        cfg_valid = 0;
        check("stall_accepted", acc, 1);
`ifdef PWLS_CFG_SHADOW_EN
        check("stall_cycles", stalls, 0);

        // Shadow commit timing, including a write coincident with the tick
        advance_to(1, 3);
        write_cfg(0, 3, 'h155);
        advance_to(0, 0);
        check("shadow_amp_after_tick", alu_amp, 'h155);
        advance_to(3, STEPS - 1);
        write_cfg(0, 3, 'h0AA);
        check("shadow_coincident_not_yet", alu_amp, 'h155);
        advance_to(0, 0);
        advance_to(3, 0);
        advance_to(0, 0);
        check("shadow_coincident_next", alu_amp, 'h0AA);
`else
        check("stall_cycles", stalls, STEPS);
        check("stall_release_ch", cur_ch, 3);
`endif

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            run        = ($urandom_range(0, 9) != 0);
            cfg_valid  = ($urandom_range(0, 2) == 0);
            cfg_ch     = 2'($urandom);
            cfg_reg    = 3'($urandom);
            cfg_data   = 16'($urandom);
            src1_sel   = 3'($urandom);
            dest_sel   = 2'($urandom);
            alu_result = 12'($urandom);
            cycle();
        end
        cfg_valid = 0; dest_sel = 0;

        // Asynchronous reset mid-sample
        run = 1;
        advance_to(2, 5);
        check("pre_reset_ch", cur_ch, 2);
        check("pre_reset_state", alu_state, 5);
        #2 reset = 1;
        #1;
        check("rst_async_ch", cur_ch, 0);
        check("rst_async_state", alu_state, 0);
        check("rst_async_tick", sample_tick, 0);
        check("rst_async_ready", cfg_ready, 1);
        check("rst_async_phase", alu_phase, 0);
        check("rst_async_amp", alu_amp, 0);
        model_reset();
        #10 reset = 0;
        repeat (40) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
